// File: rtl/weight_fetch_ctrl.sv
// Weight fetch sequencer: walks one layer's region of the weight SRAM and streams the
// words to the PE array through a credit-limited skid FIFO that hides the SRAM read latency.
module weight_fetch_ctrl #(
   parameter int DATA_W       = 100,
   parameter int ADDR_W       = 17,
   parameter int FIFO_DEPTH   = 4,
   parameter int CONV1_W_BASE = 0,
   parameter int CONV1_W_NUM  = 20,
   parameter int CONV1_B_BASE = 20,
   parameter int CONV1_B_NUM  = 1,
   parameter int CONV2_W_BASE = 21,
   parameter int CONV2_W_NUM  = 1000,
   parameter int CONV2_B_BASE = 1021,
   parameter int CONV2_B_NUM  = 2,
   parameter int FC1_W_BASE   = 1100,
   parameter int FC1_W_NUM    = 16000,
   parameter int SCORE_W_BASE = 17100,
   parameter int SCORE_W_NUM  = 200
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [1:0]        layer_sel,
   output logic              busy,
   output logic              done,
   output logic              sram_csb,
   output logic [ADDR_W-1:0] sram_raddr,
   input  logic [DATA_W-1:0] sram_rdata,
   output logic              w_valid,
   input  logic              w_ready,
   output logic [DATA_W-1:0] w_data,
   output logic              w_is_bias,
   output logic              w_last
);
   localparam int CNT_W = 15;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int OCC_W = PTR_W + 1;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH_W, S_FETCH_B, S_DRAIN, S_DONE
   } state_t;

   state_t             state_reg, state_next;
   logic [1:0]         layer_reg;
   logic [ADDR_W-1:0]  addr_reg;
   logic [CNT_W-1:0]   remaining_reg;
   logic [OCC_W-1:0]   fifo_count_reg, outstanding_reg;
   logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
   logic               bias_s1_reg, last_s1_reg;
   logic               valid_s2_reg, bias_s2_reg, last_s2_reg;
   logic [DATA_W+1:0]  fifo_mem [FIFO_DEPTH];
   logic [DATA_W+1:0]  head;

   logic               issue, issue_final, issue_last_tag, has_bias;
   logic               push, pop;
   logic [ADDR_W-1:0]  w_base, b_base;
   logic [CNT_W-1:0]   w_num, b_num;

   // Region lookup: weight region from the requested layer, bias region from the latched one.
   always_comb begin
      w_base = ADDR_W'(CONV1_W_BASE);
      w_num  = CNT_W'(CONV1_W_NUM);
      case (layer_sel)
         2'd0: begin w_base = ADDR_W'(CONV1_W_BASE); w_num = CNT_W'(CONV1_W_NUM); end
         2'd1: begin w_base = ADDR_W'(CONV2_W_BASE); w_num = CNT_W'(CONV2_W_NUM); end
         2'd2: begin w_base = ADDR_W'(FC1_W_BASE);   w_num = CNT_W'(FC1_W_NUM);   end
         default: begin w_base = ADDR_W'(SCORE_W_BASE); w_num = CNT_W'(SCORE_W_NUM); end
      endcase
      if (layer_reg[0]) begin
         b_base = ADDR_W'(CONV2_B_BASE);
         b_num  = CNT_W'(CONV2_B_NUM);
      end else begin
         b_base = ADDR_W'(CONV1_B_BASE);
         b_num  = CNT_W'(CONV1_B_NUM);
      end
      has_bias = ~layer_reg[1];
   end

   always_ff @(posedge clk) begin
      if (rst) state_reg <= S_IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:    if (start) state_next = S_FETCH_W;
         S_FETCH_W: if (issue_final) state_next = has_bias ? S_FETCH_B : S_DRAIN;
         S_FETCH_B: if (issue_final) state_next = S_DRAIN;
         S_DRAIN:   if (outstanding_reg == '0 && fifo_count_reg == '0) state_next = S_DONE;
         S_DONE:    state_next = S_IDLE;
         default:   state_next = S_IDLE;
      endcase
   end

   // Credit check counts reads still in the SRAM pipe, so a push always finds a free slot.
   always_comb begin
      busy  = (state_reg != S_IDLE);
      done  = (state_reg == S_DONE);
      issue = (state_reg == S_FETCH_W || state_reg == S_FETCH_B) &&
              (remaining_reg != '0) &&
              ((fifo_count_reg + outstanding_reg) < OCC_W'(FIFO_DEPTH));
      issue_final    = issue && (remaining_reg == CNT_W'(1));
      issue_last_tag = issue_final && ((state_reg == S_FETCH_B) || !has_bias);
      push    = valid_s2_reg;
      w_valid = (fifo_count_reg != '0);
      pop     = w_valid && w_ready;
      head      = fifo_mem[rd_ptr_reg];
      w_data    = head[DATA_W-1:0];
      w_is_bias = w_valid && head[DATA_W];
      w_last    = w_valid && head[DATA_W+1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         layer_reg     <= 2'd0;
         addr_reg      <= '0;
         remaining_reg <= '0;
      end else if (state_reg == S_IDLE && start) begin
         layer_reg     <= layer_sel;
         addr_reg      <= w_base;
         remaining_reg <= w_num;
      end else if (issue) begin
         if (state_reg == S_FETCH_W && issue_final && has_bias) begin
            addr_reg      <= b_base;
            remaining_reg <= b_num;
         end else begin
            addr_reg      <= addr_reg + ADDR_W'(1);
            remaining_reg <= remaining_reg - CNT_W'(1);
         end
      end
   end

   // Tags ride alongside the read: stage 1 with the issue, stage 2 with the returning data.
   always_ff @(posedge clk) begin
      if (rst) begin
         sram_csb     <= 1'b1;
         sram_raddr   <= '0;
         bias_s1_reg  <= 1'b0;
         last_s1_reg  <= 1'b0;
         valid_s2_reg <= 1'b0;
         bias_s2_reg  <= 1'b0;
         last_s2_reg  <= 1'b0;
      end else begin
         sram_csb     <= ~issue;
         if (issue) sram_raddr <= addr_reg;
         bias_s1_reg  <= issue && (state_reg == S_FETCH_B);
         last_s1_reg  <= issue_last_tag;
         valid_s2_reg <= ~sram_csb;
         bias_s2_reg  <= bias_s1_reg;
         last_s2_reg  <= last_s1_reg;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fifo_count_reg  <= '0;
         outstanding_reg <= '0;
         wr_ptr_reg      <= '0;
         rd_ptr_reg      <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         case ({push, pop})
            2'b10:   fifo_count_reg <= fifo_count_reg + OCC_W'(1);
            2'b01:   fifo_count_reg <= fifo_count_reg - OCC_W'(1);
            default: fifo_count_reg <= fifo_count_reg;
         endcase
         case ({issue, push})
            2'b10:   outstanding_reg <= outstanding_reg + OCC_W'(1);
            2'b01:   outstanding_reg <= outstanding_reg - OCC_W'(1);
            default: outstanding_reg <= outstanding_reg;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_reg] <= {last_s2_reg, bias_s2_reg, sram_rdata};
   end

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Bench for weight_fetch_ctrl: an SRAM model with address-derived contents and a
// sequence model of each layer's expected word stream checked every cycle.
module tb_weight_fetch_ctrl;
   localparam int DEPTH = 4;
   localparam int WB[4] = '{0, 21, 1100, 17100};
   localparam int WN[4] = '{20, 1000, 16000, 200};
   localparam int BB[4] = '{20, 1021, 0, 0};
   localparam int BN[4] = '{1, 2, 0, 0};

   typedef struct {
      int addr;
      bit bias;
      bit last;
   } entry_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  layer_sel = 2'd0;
   logic        busy, done, sram_csb;
   logic [16:0] sram_raddr;
   logic [99:0] sram_rdata = '0;
   logic        w_valid;
   logic        w_ready = 1'b0;
   logic [99:0] w_data;
   logic        w_is_bias, w_last;

   int checks = 0;
   int passes = 0;
   int ready_mode = 1;

   entry_t seq[$];
   bit   active = 0;
   int   issue_idx = 0, pop_idx = 0, done_count = 0, cyc = 0;
   int   run_pops = 0, run_bias = 0, run_lasts = 0, run_issues = 0;
   int   run_first = -1, run_last_addr = -1, run_last_tag_addr = -1;
   int   first_issue_cyc = 0, last_issue_cyc = 0;
   bit   hold_pending = 0;
   logic [99:0] hold_data;
   logic hold_bias, hold_last;

   always #5 clk = ~clk;

   weight_fetch_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .layer_sel(layer_sel),
      .busy(busy), .done(done), .sram_csb(sram_csb), .sram_raddr(sram_raddr),
      .sram_rdata(sram_rdata), .w_valid(w_valid), .w_ready(w_ready),
      .w_data(w_data), .w_is_bias(w_is_bias), .w_last(w_last)
   );

   function automatic logic [99:0] word_of(int a);
      logic [31:0] h1, h2, h3;
      h1 = a * 32'h9E37_79B1;
      h2 = a ^ 32'h5A5A_1234;
      h3 = a + 7;
      return {a[16:0], h1, h2, h3[18:0]};
   endfunction

   always @(posedge clk) if (!sram_csb) sram_rdata <= word_of(int'(sram_raddr));

   task automatic chk_i(input string name, input int got, input int exp);
      checks++;
      if (got == exp) passes++;
      else $display("FAIL %s: got %0d expected %0d", name, got, exp);
   endtask

   task automatic chk_w(input string name, input logic [99:0] got, input logic [99:0] exp);
      checks++;
      if (got == exp) passes++;
      else $display("FAIL %s: got %h expected %h", name, got, exp);
   endtask

   // Expected stream: weight region in address order, then bias region; last flag on the final word.
   task automatic build_seq(input int l);
      int total;
      entry_t e;
      total = WN[l] + BN[l];
      seq.delete();
      for (int i = 0; i < total; i++) begin
         e.bias = (i >= WN[l]);
         e.addr = e.bias ? BB[l] + (i - WN[l]) : WB[l] + i;
         e.last = (i == total - 1);
         seq.push_back(e);
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0: w_ready = 1'b0;
            1: w_ready = 1'b1;
            default: w_ready = ($urandom_range(0, 1) == 1);
         endcase
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            active = 0; seq.delete(); issue_idx = 0; pop_idx = 0; hold_pending = 0;
         end else begin
            chk_i("busy", int'(busy), int'(active));
            if (!active && start) begin
               build_seq(int'(layer_sel));
               active = 1; issue_idx = 0; pop_idx = 0;
               run_pops = 0; run_bias = 0; run_lasts = 0; run_issues = 0;
               run_first = -1; run_last_addr = -1; run_last_tag_addr = -1;
            end
            if (!sram_csb) begin
               if (issue_idx >= seq.size()) chk_i("extra_issue", issue_idx, seq.size() - 1);
               else chk_i("raddr", int'(sram_raddr), seq[issue_idx].addr);
               if (run_issues == 0) first_issue_cyc = cyc;
               last_issue_cyc = cyc;
               issue_idx++; run_issues++;
            end
            if (issue_idx - pop_idx > DEPTH) chk_i("credit", issue_idx - pop_idx, DEPTH);
            if (hold_pending)
               chk_i("hold", int'(w_valid && w_data == hold_data &&
                                  w_is_bias == hold_bias && w_last == hold_last), 1);
            if (w_valid && w_ready) begin
               if (pop_idx >= seq.size()) chk_i("extra_word", pop_idx, seq.size() - 1);
               else begin
                  chk_w("w_data", w_data, word_of(seq[pop_idx].addr));
                  chk_i("w_is_bias", int'(w_is_bias), int'(seq[pop_idx].bias));
                  chk_i("w_last", int'(w_last), int'(seq[pop_idx].last));
                  if (run_first < 0) run_first = int'(w_data[99:83]);
                  run_last_addr = int'(w_data[99:83]);
                  if (w_last) begin run_lasts++; run_last_tag_addr = int'(w_data[99:83]); end
                  if (w_is_bias) run_bias++;
               end
               pop_idx++; run_pops++;
            end
            hold_pending = w_valid && !w_ready;
            hold_data = w_data; hold_bias = w_is_bias; hold_last = w_last;
            if (done) begin
               chk_i("done_drained", int'(active && pop_idx == seq.size() &&
                                         issue_idx == seq.size()), 1);
               done_count++;
               active = 0;
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic start_layer(input int l);
      start = 1'b1;
      layer_sel = 2'(l);
      step(1);
      start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      int target;
      int n;
      target = done_count + 1;
      n = 0;
      while (done_count < target && n < budget) begin
         step(1);
         n++;
      end
      chk_i(name, int'(done_count >= target), 1);
   endtask

   task automatic check_reset(input string tag);
      chk_i({tag, "_busy"}, int'(busy), 0);
      chk_i({tag, "_done"}, int'(done), 0);
      chk_i({tag, "_csb"}, int'(sram_csb), 1);
      chk_i({tag, "_raddr"}, int'(sram_raddr), 0);
      chk_i({tag, "_valid"}, int'(w_valid), 0);
      chk_i({tag, "_bias"}, int'(w_is_bias), 0);
      chk_i({tag, "_last"}, int'(w_last), 0);
   endtask

   task automatic check_run(input string tag, input int pops, input int bias,
                            input int first, input int last);
      chk_i({tag, "_pops"}, run_pops, pops);
      chk_i({tag, "_bias_words"}, run_bias, bias);
      chk_i({tag, "_last_count"}, run_lasts, 1);
      chk_i({tag, "_first_addr"}, run_first, first);
      chk_i({tag, "_last_addr"}, run_last_addr, last);
      chk_i({tag, "_last_tag_addr"}, run_last_tag_addr, last);
   endtask

   initial begin
      int dc;
      rst = 1'b1;
      step(3);
      check_reset("rst0");
      rst = 1'b0;
      step(2);

      // conv1 with the consumer always ready
      ready_mode = 1;
      start_layer(0);
      wait_done("c1_done", 200);
      check_run("c1", 21, 1, 0, 20);
      chk_i("c1_issue_span", last_issue_cyc - first_issue_cyc, 20);
      chk_i("c1_idle_after", int'(busy), 0);

      // conv2 against a randomly stalling consumer
      ready_mode = 2;
      start_layer(1);
      wait_done("c2_done", 8000);
      check_run("c2", 1002, 2, 21, 1022);

      // score: consumer stalled, so only the credit limit of reads goes out
      ready_mode = 0;
      start_layer(3);
      step(9);
      chk_i("sc_stall_issues", run_issues, 4);
      chk_i("sc_stall_valid", int'(w_valid), 1);
      ready_mode = 1;
      wait_done("sc_done", 1000);
      check_run("sc", 200, 0, 17100, 17299);

      // fc1 with a stray start while busy
      start_layer(2);
      step(5);
      start_layer(0);
      wait_done("fc1_done", 20000);
      check_run("fc1", 16000, 0, 1100, 17099);
      dc = done_count;
      step(30);
      chk_i("fc1_single_done", done_count, dc);
      chk_i("fc1_idle_after", int'(busy), 0);

      // reset in the middle of fc1
      start_layer(2);
      for (int i = 0; i < 200 && run_pops < 37; i++) step(1);
      chk_i("fc1r_pops", run_pops, 37);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      check_reset("rst1");
      step(3);
      chk_i("rst1_no_stale_valid", int'(w_valid), 0);
      chk_i("rst1_no_issue", int'(sram_csb), 1);

      start_layer(0);
      wait_done("c1b_done", 200);
      check_run("c1b", 21, 1, 0, 20);
      chk_i("c1b_issue_span", last_issue_cyc - first_issue_cyc, 20);

      // back-to-back: start in the cycle right after done
      dc = done_count;
      start_layer(3);
      chk_i("b2b_busy", int'(busy), 1);
      wait_done("b2b_done", 1000);
      check_run("b2b", 200, 0, 17100, 17299);
      chk_i("b2b_done_count", done_count, dc + 1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/weight_fetch_ctrl.md
Name: weight_fetch_ctrl

Overview:
- Sequences reads from the 100-bit weight SRAM (sram_20000x100b) for one layer at a time and streams the words to the PE array over a valid/ready interface.
- Owns the SRAM read port (csb, raddr) and hides the 1-cycle read latency behind a small skid FIFO.
- Walks the fixed weight map (conv1/conv2 weights then bias; fc1 and score weights only), tags bias words and the last word, and pulses done when the stream is fully drained.

Parameters:
- DATA_W, 100, SRAM word width (25 weights x 4 bit)
- ADDR_W, 17, SRAM read address width
- FIFO_DEPTH, 4, output skid FIFO entries (power of 2, >= 4)
- CONV1_W_BASE, 0, CONV1_W_NUM, 20, CONV1_B_BASE, 20, CONV1_B_NUM, 1
- CONV2_W_BASE, 21, CONV2_W_NUM, 1000, CONV2_B_BASE, 1021, CONV2_B_NUM, 2
- FC1_W_BASE, 1100, FC1_W_NUM, 16000
- SCORE_W_BASE, 17100, SCORE_W_NUM, 200

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle request; accepted only in IDLE
- layer_sel  in  2  0=conv1, 1=conv2, 2=fc1, 3=score; sampled with start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the last word is handed over
- sram_csb  out  1  SRAM chip enable, active low; low = read issued this cycle
- sram_raddr  out  17  SRAM read address, meaningful when sram_csb=0
- sram_rdata  in  100  SRAM read data, valid in the cycle after the issue
- w_valid  out  1  output word valid
- w_ready  in  1  consumer ready
- w_data  out  100  weight word, FIFO head
- w_is_bias  out  1  head word comes from a bias region
- w_last  out  1  head word is the final word of the layer

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, FIFO emptied, outstanding=0. Outputs: busy=0, done=0, sram_csb=1, sram_raddr=0, w_valid=0, w_is_bias=0, w_last=0. Reset overrides everything, including a fetch in progress. A read already in flight is discarded.
- States:
  - IDLE: wait for start.
  - FETCH_W: issue the weight region.
  - FETCH_B: issue the bias region (conv1/conv2 only).
  - DRAIN: issues are finished; wait until outstanding=0 and the FIFO is empty.
  - DONE: done=1 for one cycle, then return to IDLE.
- IDLE, start=1: latch layer_sel, load the address and remaining count for the weight region, go to FETCH_W. start is ignored in every other state.
- Read issue:
  - sram_csb and sram_raddr are registered outputs.
  - A read is issued in a cycle when all of these hold: state is FETCH_W or FETCH_B, remaining>0, and fifo_count+outstanding < FIFO_DEPTH.
  - Each issue increments the address and decrements remaining.
  - When FETCH_W reaches remaining=0: conv1/conv2 go to FETCH_B with the bias base and count loaded; fc1/score go to DRAIN. When FETCH_B reaches remaining=0: go to DRAIN.
- Latency:
  - A read issued in cycle N (sram_csb=0, raddr=A) gives sram_rdata=mem[A] in cycle N+1.
  - That data is pushed into the FIFO at the end of N+1, together with its is_bias and last tags, which are pipelined alongside the issue.
  - w_valid is high no earlier than cycle N+2.
- Throughput: with w_ready held high, one word per cycle is sustained after a 2-cycle fill.
- Output handshake:
  - A transfer happens when w_valid and w_ready are both high.
  - w_data, w_is_bias and w_last hold steady while w_valid=1 and w_ready=0.
  - A FIFO push and pop in the same cycle are both allowed.
  - The FIFO never overflows. Credit counting guarantees this, so there is no full-flag path.
- w_last: set on exactly one word, the last issued word of the layer (the last bias word for conv1/conv2, the last weight word otherwise).
- Counts: remaining is 15 bits (max 16000). Addresses never wrap; the highest address issued is 17299.

Test Plan:
- conv1, w_ready=1: start with layer_sel=0 -> raddr 0..20 issued on consecutive cycles; 21 words out in address order; w_is_bias=1 and w_last=1 on word 21 only; one done pulse; busy returns to 0.
- conv2 with random w_ready (50%): 1002 words, addresses 21..1022; bias on the final 2 words; no drops or duplicates; sram_csb=1 whenever the FIFO plus in-flight reads equal 4.
- score, w_ready held 0 for 10 cycles after start, then 1: exactly 4 reads issued and then stall; on release, 200 words from 17100..17299; w_is_bias never set.
- start pulsed while busy (fc1 running) -> ignored; exactly 16000 words and one done.
- rst asserted mid-fc1 (after 37 words) -> next cycle all outputs at reset values; a following conv1 start behaves exactly as in scenario 1.
- Back-to-back: start issued in the cycle after done -> accepted; the second layer streams correctly.
